mips_trace_monitor: RTL and testbench

Passive observer that sits on the single-cycle MIPS core's status outputs (current PC, next PC, fetched instruction) and runs on the core's clock. Each cycle it checks PC continuity, counts retired instructions and detects the self-loop halt idiom. Each cycle's trace record is buffered in a small FIFO and drained through a valid/ready stream toward a logger or host link. It is the consuming end of the core's instruction/PC observation interface and replaces waveform inspection with checked, streamable trace data.

---
 rtl/mips_trace_pkg.sv | 19 +
 rtl/trace_fifo.sv | 49 ++++
 rtl/mips_trace_monitor.sv | 133 +++++++++++++
 tb/tb_mips_trace_monitor.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_trace_pkg.sv
// Shared types and constants for the MIPS trace monitor and its trace FIFO.
package mips_trace_pkg;

  localparam int WORD_W = 32;
  localparam int REC_W  = 2 * WORD_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
    logic              err;
  } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted when the
// same cycle also pops.
module trace_fifo
  import mips_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = REC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero when empty so outputs are defined without resetting storage.
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mips_trace_monitor.sv
// Observes the single-cycle MIPS core's PC/instruction outputs, checks PC
// continuity, counts retirements, detects the self-loop halt and streams records.
module mips_trace_monitor
  import mips_trace_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int HALT_REPEAT = 4
) (
  input  logic        i_clk,
  input  logic        i_arst,
  input  logic        i_en,
  input  logic [31:0] i_instruction,
  input  logic [31:0] i_pc_cur,
  input  logic [31:0] i_pc_next,
  output logic        o_trace_valid,
  input  logic        i_trace_ready,
  output logic [31:0] o_trace_pc,
  output logic [31:0] o_trace_instr,
  output logic        o_trace_err,
  output logic [31:0] o_retired,
  output logic [15:0] o_err_cnt,
  output logic        o_overflow,
  output logic        o_halted
);

  localparam int HC_W = $clog2(HALT_REPEAT + 1);

  state_t            state;
  state_t            state_nxt;
  logic              sample;
  logic              err;
  logic              self_loop;
  logic              halt_hit;
  logic              pop;
  logic              full;
  logic              empty;
  logic              prev_valid;
  logic [WORD_W-1:0] prev_next;
  logic [HC_W-1:0]   halt_cnt;
  logic [31:0]       retired;
  logic [15:0]       err_cnt;
  logic              overflow;
  trace_rec_t        rec;
  trace_rec_t        head;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A RUN cycle with the enable dropped is the exit cycle and is not sampled.
  assign sample    = (state == RUN) && i_en;
  assign self_loop = (i_pc_next == i_pc_cur);
  assign halt_hit  = sample && self_loop && (halt_cnt == HC_W'(HALT_REPEAT - 1));
  assign err       = (i_pc_cur[1:0] != 2'b00) || (prev_valid && (i_pc_cur != prev_next));
  assign rec       = '{pc: i_pc_cur, instr: i_instruction, err: err};
  assign pop       = !empty && i_trace_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_en) state_nxt = RUN;
      RUN: begin
        if (!i_en)         state_nxt = IDLE;
        else if (halt_hit) state_nxt = HALT;
      end
      HALT:    if (!i_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Continuity and halt tracking restart whenever the monitor passes through IDLE.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      prev_valid <= 1'b0;
      halt_cnt   <= '0;
    end else if (state == IDLE) begin
      prev_valid <= 1'b0;
      halt_cnt   <= '0;
    end else if (sample) begin
      prev_valid <= 1'b1;
      halt_cnt   <= self_loop ? halt_cnt + HC_W'(1) : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (sample) prev_next <= i_pc_next;
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      retired  <= '0;
      err_cnt  <= '0;
      overflow <= 1'b0;
    end else if (sample) begin
      retired <= sat_inc32(retired);
      if (err)          err_cnt  <= sat_inc16(err_cnt);
      if (full && !pop) overflow <= 1'b1;
    end
  end

  trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_arst),
    .push  (sample),
    .pop   (pop),
    .wdata (rec),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign o_trace_valid = !empty;
  assign o_trace_pc    = head.pc;
  assign o_trace_instr = head.instr;
  assign o_trace_err   = head.err;
  assign o_retired     = retired;
  assign o_err_cnt     = err_cnt;
  assign o_overflow    = overflow;
  assign o_halted      = (state == HALT);

endmodule

// File: tb/tb_mips_trace_monitor.sv
// Directed table-driven bench for mips_trace_monitor plus hand-written
// sequences for halt drain, overflow, full-with-pop and mid-run reset.
module tb_mips_trace_monitor;

  logic        i_clk = 1'b0;
  logic        i_arst;
  logic        i_en;
  logic [31:0] i_instruction;
  logic [31:0] i_pc_cur;
  logic [31:0] i_pc_next;
  logic        o_trace_valid;
  logic        i_trace_ready;
  logic [31:0] o_trace_pc;
  logic [31:0] o_trace_instr;
  logic        o_trace_err;
  logic [31:0] o_retired;
  logic [15:0] o_err_cnt;
  logic        o_overflow;
  logic        o_halted;

  int n_total = 0;
  int n_pass  = 0;

  localparam logic [31:0] IMASK = 32'hA5A5_0000;

  mips_trace_monitor #(.FIFO_DEPTH(8), .HALT_REPEAT(4)) dut (
    .i_clk         (i_clk),
    .i_arst        (i_arst),
    .i_en          (i_en),
    .i_instruction (i_instruction),
    .i_pc_cur      (i_pc_cur),
    .i_pc_next     (i_pc_next),
    .o_trace_valid (o_trace_valid),
    .i_trace_ready (i_trace_ready),
    .o_trace_pc    (o_trace_pc),
    .o_trace_instr (o_trace_instr),
    .o_trace_err   (o_trace_err),
    .o_retired     (o_retired),
    .o_err_cnt     (o_err_cnt),
    .o_overflow    (o_overflow),
    .o_halted      (o_halted)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        en;
    logic [31:0] pc;
    logic [31:0] nx;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic        eerr;
    logic [31:0] eret;
    logic [15:0] eec;
    logic        eh;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic en, input logic [31:0] pc, input logic [31:0] nx,
                              input logic rdy, input logic ev, input logic [31:0] epc,
                              input logic eerr, input logic [31:0] eret,
                              input logic [15:0] eec, input logic eh);
    vec_t v;
    v.en = en; v.pc = pc; v.nx = nx; v.rdy = rdy; v.ev = ev; v.epc = epc;
    v.eerr = eerr; v.eret = eret; v.eec = eec; v.eh = eh;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic cyc(input logic en, input logic [31:0] pc, input logic [31:0] nx, input logic rdy);
    i_en          = en;
    i_pc_cur      = pc;
    i_pc_next     = nx;
    i_instruction = pc ^ IMASK;
    i_trace_ready = rdy;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_en          = 1'b0;
    i_trace_ready = 1'b0;
    i_arst        = 1'b0;
    #2;
    @(negedge i_clk);
    i_arst = 1'b1;
  endtask

  task automatic drain(input string nm, input int n_exp, input logic [31:0] pc0,
                       input int stp, input logic en);
    int n = 0;
    while (o_trace_valid && n < 20) begin
      chk({nm, "_pc"}, 64'(o_trace_pc), 64'(pc0 + 32'(stp * n)));
      chk({nm, "_instr"}, 64'(o_trace_instr), 64'((pc0 + 32'(stp * n)) ^ IMASK));
      cyc(en, 32'h0, 32'h4, 1'b1);
      n++;
    end
    chk({nm, "_count"}, 64'(n), 64'(n_exp));
  endtask

  initial begin
    i_en = 0; i_instruction = 0; i_pc_cur = 0; i_pc_next = 0; i_trace_ready = 0;
    i_arst = 1'b0;
    #3;
    chk("rst_valid",   64'(o_trace_valid), 64'd0);
    chk("rst_pc",      64'(o_trace_pc),    64'd0);
    chk("rst_instr",   64'(o_trace_instr), 64'd0);
    chk("rst_err",     64'(o_trace_err),   64'd0);
    chk("rst_retired", 64'(o_retired),     64'd0);
    chk("rst_errcnt",  64'(o_err_cnt),     64'd0);
    chk("rst_ovf",     64'(o_overflow),    64'd0);
    chk("rst_halted",  64'(o_halted),      64'd0);
    @(negedge i_clk);
    i_arst = 1'b1;

    //             en  pc        nx        rdy ev  epc       err ret  ec  halted
    tbl[0]  = mk(1, 32'h00, 32'h00, 1, 0, 32'h00, 0, 0,  0, 0);
    tbl[1]  = mk(1, 32'h00, 32'h04, 1, 1, 32'h00, 0, 1,  0, 0);
    tbl[2]  = mk(1, 32'h04, 32'h08, 1, 1, 32'h04, 0, 2,  0, 0);
    tbl[3]  = mk(1, 32'h08, 32'h0C, 1, 1, 32'h08, 0, 3,  0, 0);
    tbl[4]  = mk(1, 32'h0C, 32'h10, 1, 1, 32'h0C, 0, 4,  0, 0);
    tbl[5]  = mk(1, 32'h10, 32'h40, 1, 1, 32'h10, 0, 5,  0, 0);
    tbl[6]  = mk(1, 32'h44, 32'h48, 1, 1, 32'h44, 1, 6,  1, 0);
    tbl[7]  = mk(1, 32'h4A, 32'h4E, 1, 1, 32'h4A, 1, 7,  2, 0);
    tbl[8]  = mk(1, 32'h4E, 32'h52, 1, 1, 32'h4E, 1, 8,  3, 0);
    tbl[9]  = mk(1, 32'h50, 32'h54, 1, 1, 32'h50, 1, 9,  4, 0);
    tbl[10] = mk(1, 32'h54, 32'h58, 1, 1, 32'h54, 0, 10, 4, 0);
    tbl[11] = mk(0, 32'h58, 32'h5C, 1, 0, 32'h00, 0, 10, 4, 0);
    tbl[12] = mk(1, 32'h20, 32'h20, 0, 0, 32'h00, 0, 10, 4, 0);
    tbl[13] = mk(1, 32'h20, 32'h20, 0, 1, 32'h20, 0, 11, 4, 0);
    tbl[14] = mk(1, 32'h20, 32'h20, 0, 1, 32'h20, 0, 12, 4, 0);
    tbl[15] = mk(1, 32'h20, 32'h20, 0, 1, 32'h20, 0, 13, 4, 0);
    tbl[16] = mk(1, 32'h20, 32'h20, 0, 1, 32'h20, 0, 14, 4, 1);
    tbl[17] = mk(1, 32'h20, 32'h20, 0, 1, 32'h20, 0, 14, 4, 1);
    tbl[18] = mk(1, 32'h20, 32'h20, 0, 1, 32'h20, 0, 14, 4, 1);

    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].en, tbl[i].pc, tbl[i].nx, tbl[i].rdy);
      chk($sformatf("v%0d_valid", i), 64'(o_trace_valid), 64'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("v%0d_pc", i),    64'(o_trace_pc),    64'(tbl[i].epc));
        chk($sformatf("v%0d_instr", i), 64'(o_trace_instr), 64'(tbl[i].epc ^ IMASK));
        chk($sformatf("v%0d_err", i),   64'(o_trace_err),   64'(tbl[i].eerr));
      end
      chk($sformatf("v%0d_retired", i), 64'(o_retired), 64'(tbl[i].eret));
      chk($sformatf("v%0d_errcnt", i),  64'(o_err_cnt), 64'(tbl[i].eec));
      chk($sformatf("v%0d_halted", i),  64'(o_halted),  64'(tbl[i].eh));
    end

    // Halt loop: exactly four self-loop records queued, counters frozen while halted.
    drain("halt", 4, 32'h20, 0, 1'b1);
    chk("halt_retired_hold", 64'(o_retired), 64'd14);
    chk("halt_still",        64'(o_halted),  64'd1);
    cyc(0, 32'h0, 32'h4, 1);
    chk("halt_exit", 64'(o_halted), 64'd0);

    // Backpressure: ten samples into an eight-entry FIFO.
    do_reset();
    cyc(1, 32'h0, 32'h0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 32'h100 + 32'(4 * i), 32'h104 + 32'(4 * i), 0);
    chk("ovf_retired", 64'(o_retired),     64'd10);
    chk("ovf_flag",    64'(o_overflow),    64'd1);
    chk("ovf_errcnt",  64'(o_err_cnt),     64'd0);
    chk("ovf_valid",   64'(o_trace_valid), 64'd1);
    drain("ovf", 8, 32'h100, 4, 1'b0);
    chk("ovf_sticky", 64'(o_overflow), 64'd1);

    // Full FIFO with a pop in the same sampled cycle.
    do_reset();
    cyc(1, 32'h0, 32'h0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 32'h200 + 32'(4 * i), 32'h204 + 32'(4 * i), 0);
    chk("fpop_full_noovf", 64'(o_overflow), 64'd0);
    cyc(1, 32'h220, 32'h224, 1);
    chk("fpop_noovf", 64'(o_overflow), 64'd0);
    chk("fpop_head",  64'(o_trace_pc), 64'h204);
    drain("fpop", 8, 32'h204, 4, 1'b0);

    // Reset mid-run with five records queued.
    do_reset();
    cyc(1, 32'h0, 32'h0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 32'h300 + 32'(4 * i), 32'h304 + 32'(4 * i), 0);
    chk("mrst_pre_valid",   64'(o_trace_valid), 64'd1);
    chk("mrst_pre_retired", 64'(o_retired),     64'd5);
    #2;
    i_arst = 1'b0;
    #1;
    chk("mrst_valid",   64'(o_trace_valid), 64'd0);
    chk("mrst_pc",      64'(o_trace_pc),    64'd0);
    chk("mrst_retired", 64'(o_retired),     64'd0);
    chk("mrst_errcnt",  64'(o_err_cnt),     64'd0);
    @(negedge i_clk);
    i_arst = 1'b1;
    i_en   = 1'b0;
    cyc(0, 32'h318, 32'h31C, 1);
    chk("mrst_idle_valid",   64'(o_trace_valid), 64'd0);
    chk("mrst_idle_retired", 64'(o_retired),     64'd0);
    chk("mrst_idle_halted",  64'(o_halted),      64'd0);
    cyc(1, 32'h400, 32'h404, 1);
    chk("mrst_enter_retired", 64'(o_retired), 64'd0);
    cyc(1, 32'h400, 32'h404, 1);
    chk("mrst_run_retired", 64'(o_retired),  64'd1);
    chk("mrst_run_pc",      64'(o_trace_pc), 64'h400);
    chk("mrst_run_err",     64'(o_trace_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
